// File: rtl/irq_pkg.sv
// Shared types, defaults and arbitration helper for the interrupt controller.
package irq_pkg;

   localparam int unsigned NumIrqDef = 4;
   localparam int unsigned IdWDef    = 2;
   localparam int unsigned MaxIrq    = 16;

   typedef enum logic [1:0] {
      IDLE,
      FIRE,
      SERVICE
   } irqStateT;

   // Index of the lowest set bit; returns 0 when no bit is set.
   function automatic logic [3:0] lowestSet(input logic [MaxIrq-1:0] vec);
      logic [3:0] idx;
      idx = '0;
      for (int i = MaxIrq - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser per request line followed by a rising-edge detector.
module irq_sync_edge
   import irq_pkg::*;
#(
   parameter int unsigned Width = NumIrqDef
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic [Width-1:0] rawIn,
   output logic [Width-1:0] rise
);

   logic [Width-1:0] meta1Q;
   logic [Width-1:0] syncQ;
   logic [Width-1:0] prevQ;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         meta1Q <= '0;
         syncQ  <= '0;
         prevQ  <= '0;
      end else begin
         meta1Q <= rawIn;
         syncQ  <= meta1Q;
         prevQ  <= syncQ;
      end
   end

   assign rise = syncQ & ~prevQ;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: synchronised edge capture, mask, fixed priority, single-ISR FSM.
// Optional in-service watchdog enabled by defining IRQ_TIMEOUT_EN.
module irq_controller
   import irq_pkg::*;
#(
   parameter int unsigned NUM_IRQ = NumIrqDef,
   parameter int unsigned ID_W    = IdWDef,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   input  logic               rti_done,
   output logic               interrupt,
   output logic [ID_W-1:0]    irq_id,
   output logic               in_service,
   output logic [NUM_IRQ-1:0] pending,
   output logic               timeout_err
);

   if (NUM_IRQ < 1 || NUM_IRQ > MaxIrq || (2 ** ID_W) < NUM_IRQ || TIMEOUT < 1) begin : gBadParams
      $error("irq_controller: illegal parameter combination");
   end

   // Asynchronous assert, synchronised release.
   logic [1:0] rstSyncQ;
   logic       rstN;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rstSyncQ <= '0;
      end else begin
         rstSyncQ <= {rstSyncQ[0], 1'b1};
      end
   end

   assign rstN = rstSyncQ[1];

   logic [NUM_IRQ-1:0] rise;

   irq_sync_edge #(
      .Width (NUM_IRQ)
   ) uSyncEdge (
      .clk   (clk),
      .rstN  (rstN),
      .rawIn (irq_in),
      .rise  (rise)
   );

   irqStateT           stateQ, stateD;
   logic [ID_W-1:0]    idQ, idD;
   logic [NUM_IRQ-1:0] pendingQ, pendingD;
   logic [NUM_IRQ-1:0] maskQ;
   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] grant;
   logic [3:0]         winnerFull;
   logic [ID_W-1:0]    winner;

   assign eligible   = pendingQ & maskQ;
   assign winnerFull = lowestSet(MaxIrq'(eligible));
   assign winner     = ID_W'(winnerFull);

`ifdef IRQ_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cntQ, cntD, cntInc;
   logic            errQ, errD;

   assign cntInc = cntQ + CntW'(1);
`endif

   always_comb begin
      stateD = stateQ;
      idD    = idQ;
      grant  = '0;
`ifdef IRQ_TIMEOUT_EN
      cntD   = cntQ;
      errD   = errQ;
`endif
      unique case (stateQ)
         IDLE: begin
            if (|eligible) begin
               idD    = winner;
               grant  = NUM_IRQ'(1) << winner;
               stateD = FIRE;
            end
         end
         FIRE: begin
            stateD = SERVICE;
`ifdef IRQ_TIMEOUT_EN
            cntD   = '0;
`endif
         end
         SERVICE: begin
            if (rti_done) begin
               stateD = IDLE;
            end
`ifdef IRQ_TIMEOUT_EN
            else if (cntInc == CntW'(TIMEOUT)) begin
               stateD = IDLE;
               errD   = 1'b1;
            end else begin
               cntD = cntInc;
            end
`endif
         end
         default: stateD = IDLE;
      endcase
   end

   // A fresh edge wins over a same-cycle grant of the same bit.
   assign pendingD = (pendingQ & ~grant) | rise;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         stateQ   <= IDLE;
         idQ      <= '0;
         pendingQ <= '0;
         maskQ    <= '1;
      end else begin
         stateQ   <= stateD;
         idQ      <= idD;
         pendingQ <= pendingD;
         if (mask_we) begin
            maskQ <= mask_wdata;
         end
      end
   end

`ifdef IRQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         cntQ <= '0;
         errQ <= 1'b0;
      end else begin
         cntQ <= cntD;
         errQ <= errD;
      end
   end

   assign timeout_err = errQ;
`else
   assign timeout_err = 1'b0;
`endif

   assign interrupt  = (stateQ == FIRE);
   assign in_service = (stateQ != IDLE);
   assign irq_id     = idQ;
   assign pending    = pendingQ;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller with a behavioural reference model.
module tb_irq_controller;

   localparam int NumIrq  = 4;
   localparam int IdW     = 2;
   localparam int Timeout = 8;
`ifdef IRQ_TIMEOUT_EN
   localparam bit TimeoutOn = 1'b1;
`else
   localparam bit TimeoutOn = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NumIrq-1:0] irqIn = '0;
   logic              maskWe = 1'b0;
   logic [NumIrq-1:0] maskWdata = '0;
   logic              rtiDone = 1'b0;
   logic              interrupt;
   logic [IdW-1:0]    irqId;
   logic              inService;
   logic [NumIrq-1:0] pending;
   logic              timeoutErr;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   irq_controller #(
      .NUM_IRQ (NumIrq),
      .ID_W    (IdW),
      .TIMEOUT (Timeout)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .irq_in      (irqIn),
      .mask_we     (maskWe),
      .mask_wdata  (maskWdata),
      .rti_done    (rtiDone),
      .interrupt   (interrupt),
      .irq_id      (irqId),
      .in_service  (inService),
      .pending     (pending),
      .timeout_err (timeoutErr)
   );

   // Reference model: request history, pending set, mask and a service phase
   // (0 idle, 1 pulse cycle, 2 ISR running).
   logic [NumIrq-1:0] sampHist[$];
   logic [NumIrq-1:0] mPend;
   logic [NumIrq-1:0] mMask;
   logic [IdW-1:0]    mId;
   logic              mErr;
   int                mPhase;
   int                mSvc;
   int                hold;

   task automatic modelReset();
      sampHist.delete();
      for (int i = 0; i < 3; i++) sampHist.push_back('0);
      mPend  = '0;
      mMask  = '1;
      mId    = '0;
      mErr   = 1'b0;
      mPhase = 0;
      mSvc   = 0;
   endtask

   task automatic modelStep(input logic [NumIrq-1:0] x, input logic r, input logic we,
                            input logic [NumIrq-1:0] wd, input logic rti);
      logic [NumIrq-1:0] edges, elig, grantV;
      int w;
      if (!r || hold > 0) begin
         if (!r) hold = 2;
         else hold--;
         modelReset();
         return;
      end
      // A request sampled two edges ago that was low the edge before becomes pending now.
      edges = sampHist[1] & ~sampHist[2];
      sampHist.push_front(x);
      void'(sampHist.pop_back());
      elig   = mPend & mMask;
      grantV = '0;
      if (mPhase == 0) begin
         if (elig != '0) begin
            w = 0;
            while (!elig[w]) w++;
            mId       = IdW'(w);
            grantV[w] = 1'b1;
            mPhase    = 1;
         end
      end else if (mPhase == 1) begin
         mPhase = 2;
         mSvc   = 0;
      end else begin
         mSvc++;
         if (rti) begin
            mPhase = 0;
         end else if (TimeoutOn && mSvc == Timeout) begin
            mPhase = 0;
            mErr   = 1'b1;
         end
      end
      mPend = (mPend & ~grantV) | edges;
      if (we) mMask = wd;
   endtask

   task automatic tick();
      logic [NumIrq-1:0] x, wd;
      logic r, we, rti;
      x   = irqIn;
      r   = reset;
      we  = maskWe;
      wd  = maskWdata;
      rti = rtiDone;
      @(posedge clk);
      #1;
      cyc++;
      modelStep(x, r, we, wd, rti);
   endtask

   task automatic test_reset();
      int n;
      logic [IdW-1:0] ids[4];
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         irqIn = NumIrq'($urandom);
         tick();
         checks++;
         if ({interrupt, inService, pending, irqId, timeoutErr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d got=%b exp=0", cyc,
                     {interrupt, inService, pending, irqId, timeoutErr});
         end
      end
      irqIn = '0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (interrupt !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL reset_release_quiet cyc=%0d int=%b pend=%b exp int=0 pend=0", cyc,
                     interrupt, pending);
         end
      end
      // All four sources must be enabled out of reset and served lowest first.
      n = 0;
      irqIn = 4'b1111;
      for (int i = 0; i < 40 && n < 4; i++) begin
         rtiDone = inService && !interrupt;
         tick();
         if (interrupt) begin
            ids[n] = irqId;
            n++;
         end
      end
      rtiDone = 1'b0;
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL reset_mask_all_ones got=%0d pulses exp=4", n);
      end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (ids[i] !== IdW'(i)) begin
            errors++;
            $display("FAIL reset_mask_order idx=%0d got=%0d exp=%0d", i, ids[i], i);
         end
      end
      tick();
      rtiDone = 1'b1;
      tick();
      rtiDone = 1'b0;
      irqIn = '0;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_single();
      int pulseAt = -1;
      irqIn = 4'b0100;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (interrupt && pulseAt < 0) pulseAt = i;
         checks++;
         if (interrupt !== (mPhase == 1)) begin
            errors++;
            $display("FAIL single_pulse_model cyc=%0d got=%b exp=%b", cyc, interrupt, mPhase == 1);
         end
      end
      // Edge launched in cycle 0; the pulse occupies the fifth cycle of the latency.
      checks++;
      if (pulseAt != 4) begin
         errors++;
         $display("FAIL single_latency got=%0d exp=4", pulseAt);
      end
      checks++;
      if (irqId !== 2'd2 || inService !== 1'b1) begin
         errors++;
         $display("FAIL single_service got id=%0d ins=%b exp id=2 ins=1", irqId, inService);
      end
      rtiDone = 1'b1;
      tick();
      rtiDone = 1'b0;
      checks++;
      if (inService !== 1'b0 || pending !== '0) begin
         errors++;
         $display("FAIL single_rti got ins=%b pend=%b exp ins=0 pend=0000", inService, pending);
      end
      irqIn = '0;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_priority();
      int guard = 0;
      irqIn = 4'b1010;
      while (!interrupt && guard < 10) begin
         tick();
         guard++;
      end
      checks++;
      if (interrupt !== 1'b1 || irqId !== 2'd1 || pending !== 4'b1000) begin
         errors++;
         $display("FAIL prio_first got int=%b id=%0d pend=%b exp int=1 id=1 pend=1000",
                  interrupt, irqId, pending);
      end
      rtiDone = 1'b1;  // lands on the pulse cycle and must be ignored
      tick();
      rtiDone = 1'b0;
      checks++;
      if (inService !== 1'b1 || interrupt !== 1'b0) begin
         errors++;
         $display("FAIL prio_rti_in_fire got ins=%b int=%b exp ins=1 int=0", inService, interrupt);
      end
      tick();
      tick();
      rtiDone = 1'b1;
      tick();
      rtiDone = 1'b0;
      checks++;
      if (inService !== 1'b0 || interrupt !== 1'b0 || pending !== 4'b1000) begin
         errors++;
         $display("FAIL prio_after_rti got ins=%b int=%b pend=%b exp ins=0 int=0 pend=1000",
                  inService, interrupt, pending);
      end
      tick();
      checks++;
      if (interrupt !== 1'b1 || irqId !== 2'd3 || pending !== 4'b0000) begin
         errors++;
         $display("FAIL prio_second got int=%b id=%0d pend=%b exp int=1 id=3 pend=0000",
                  interrupt, irqId, pending);
      end
      tick();
      rtiDone = 1'b1;
      tick();
      rtiDone = 1'b0;
      irqIn = '0;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_mask();
      maskWe = 1'b1;
      maskWdata = 4'b1110;
      tick();
      maskWe = 1'b0;
      irqIn = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL mask_blocked cyc=%0d got=%b exp=0", cyc, interrupt);
         end
      end
      checks++;
      if (pending !== 4'b0001 || inService !== 1'b0) begin
         errors++;
         $display("FAIL mask_capture got pend=%b ins=%b exp pend=0001 ins=0", pending, inService);
      end
      maskWe = 1'b1;
      maskWdata = 4'b1111;
      tick();
      maskWe = 1'b0;
      checks++;
      if (interrupt !== 1'b0) begin
         errors++;
         $display("FAIL mask_early got=%b exp=0", interrupt);
      end
      tick();
      checks++;
      if (interrupt !== 1'b1 || irqId !== 2'd0 || pending !== 4'b0000) begin
         errors++;
         $display("FAIL mask_release got int=%b id=%0d pend=%b exp int=1 id=0 pend=0000",
                  interrupt, irqId, pending);
      end
      tick();
      rtiDone = 1'b1;
      tick();
      rtiDone = 1'b0;
      irqIn = '0;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_random();
      int pulses = 0;
      for (int i = 0; i < 400; i++) begin
         irqIn     = irqIn ^ NumIrq'($urandom & $urandom & $urandom);
         maskWe    = ($urandom_range(0, 7) == 0);
         maskWdata = NumIrq'($urandom);
         rtiDone   = ($urandom_range(0, 3) == 0);
         tick();
         if (interrupt) pulses++;
         checks++;
         if (interrupt !== (mPhase == 1)) begin
            errors++;
            $display("FAIL rand_int cyc=%0d got=%b exp=%b", cyc, interrupt, mPhase == 1);
         end
         checks++;
         if (inService !== (mPhase != 0)) begin
            errors++;
            $display("FAIL rand_in_service cyc=%0d got=%b exp=%b", cyc, inService, mPhase != 0);
         end
         checks++;
         if (pending !== mPend) begin
            errors++;
            $display("FAIL rand_pending cyc=%0d got=%b exp=%b", cyc, pending, mPend);
         end
         checks++;
         if (irqId !== mId) begin
            errors++;
            $display("FAIL rand_irq_id cyc=%0d got=%0d exp=%0d", cyc, irqId, mId);
         end
         checks++;
         if (timeoutErr !== mErr) begin
            errors++;
            $display("FAIL rand_timeout_err cyc=%0d got=%b exp=%b", cyc, timeoutErr, mErr);
         end
      end
      maskWe = 1'b0;
      rtiDone = 1'b0;
      checks++;
      if (pulses < 5) begin
         errors++;
         $display("FAIL rand_activity got=%0d pulses exp>=5", pulses);
      end
   endtask

   task automatic test_reset_service();
      int guard = 0;
      reset = 1'b0;
      irqIn = '0;
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      irqIn = 4'b0001;
      while (!inService && guard < 10) begin
         tick();
         guard++;
      end
      tick();
      irqIn = 4'b0101;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (pending !== 4'b0100 || inService !== 1'b1) begin
         errors++;
         $display("FAIL rsvc_setup got pend=%b ins=%b exp pend=0100 ins=1", pending, inService);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (inService !== 1'b0 || pending !== '0 || interrupt !== 1'b0 || irqId !== '0) begin
         errors++;
         $display("FAIL rsvc_async got ins=%b pend=%b int=%b id=%0d exp all 0",
                  inService, pending, interrupt, irqId);
      end
      tick();
      tick();
      irqIn = '0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (interrupt !== 1'b0 || inService !== 1'b0) begin
            errors++;
            $display("FAIL rsvc_quiet cyc=%0d got int=%b ins=%b exp 0 0", cyc, interrupt, inService);
         end
      end
   endtask

   task automatic test_timeout();
      int guard = 0;
      checks++;
      if (timeoutErr !== 1'b0) begin
         errors++;
         $display("FAIL tmo_initial got=%b exp=0", timeoutErr);
      end
`ifdef IRQ_TIMEOUT_EN
      irqIn = 4'b0001;
      while (!interrupt && guard < 10) begin
         tick();
         guard++;
      end
      tick();  // now in SERVICE
      for (int j = 1; j <= Timeout; j++) begin
         tick();
         checks++;
         if (inService !== (j < Timeout) || timeoutErr !== (j >= Timeout)) begin
            errors++;
            $display("FAIL tmo_count j=%0d got ins=%b err=%b exp ins=%b err=%b", j, inService,
                     timeoutErr, j < Timeout, j >= Timeout);
         end
      end
      rtiDone = 1'b1;
      tick();
      rtiDone = 1'b0;
      checks++;
      if (timeoutErr !== 1'b1 || inService !== 1'b0 || interrupt !== 1'b0) begin
         errors++;
         $display("FAIL tmo_late_rti got err=%b ins=%b int=%b exp err=1 ins=0 int=0",
                  timeoutErr, inService, interrupt);
      end
      irqIn = '0;
      for (int i = 0; i < 4; i++) tick();
`endif
   endtask

   initial begin
      modelReset();
      hold = 2;
      test_reset();
      test_single();
      test_priority();
      test_mask();
      test_random();
      test_reset_service();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
